song_tutor: RTL and testbench
=============================

# song_tutor

Parametrised play-along trainer that sits beside the piano keyboard decoder and consumes its decoded note stream. A song of up to MAX_LEN notes is loaded at run time through a valid/ready port. The block then lights the LED pattern of the next expected note and advances only on a correct press followed by a release. It adds a strict or lenient mode, saturating mistake counting, optional looping and completion/error pulses.

## Interface
- NOTE_W, 4: width of note codes; code 0 is NONE (no key pressed).
- MAX_LEN, 64: song memory depth, ≥ 2.
- LED_W, 8: LED bus width.
- MIST_W, 8: mistake counter width.
- IDX_W, $clog2(MAX_LEN): width of the song index (derived).

Ports:
- CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- note  in  NOTE_W  decoded key from the piano decoder, synchronous to CLK.
- ld_valid  in  1  load beat valid.
- ld_note  in  NOTE_W  note to store; NONE is a legal rest-free value and is stored as-is, but it can never be matched.
- ld_last  in  1  marks the final note of the song.
- ld_ready  out  1  high only in IDLE.
- play_start  in  1  single-cycle start/restart.
- mode  in  2  bit 0: 0 = strict, 1 = lenient; bit 1: 1 = loop on completion.
- Led  out  LED_W  pattern of the expected note; all-zero when not playing.
- idx  out  IDX_W  current song position.
- mistakes  out  MIST_W  saturating wrong-note count.
- busy  out  1  high in WAIT_PRESS and WAIT_REL.
- done  out  1  one-cycle pulse on completion.
- error  out  1  one-cycle pulse per wrong press.

## Operation
- **States:** IDLE, WAIT_PRESS, WAIT_REL. Reset enters IDLE with wr_ptr = 0, len_valid = 0 and all outputs 0.
- **Load (IDLE only):**
  - Each ld_valid && ld_ready cycle writes ld_note at wr_ptr, then wr_ptr++.
  - When ld_last is high, or when the write lands at MAX_LEN−1: len ← wr_ptr+1, len_valid ← 1, wr_ptr ← 0.
  - A beat while wr_ptr = 0 and len_valid = 1 begins a new song and clears len_valid.
  - ld_valid outside IDLE is ignored.
- **Start:** play_start in any state with len_valid = 1 → WAIT_PRESS with idx ← 0, mistakes ← 0, hit ← 0. play_start with len_valid = 0 is ignored.
- **WAIT_PRESS:**
  - note == NONE: stay.
  - note == song[idx]: hit ← 1 → WAIT_REL.
  - Any other non-NONE note: error pulse, mistakes++ (saturating at all-ones), hit ← 0 → WAIT_REL. In strict mode idx ← 0 at the same time.
- **WAIT_REL:**
  - Stay while note ≠ NONE. The held key changing value is not a new press.
  - On NONE with hit = 0: → WAIT_PRESS, idx unchanged.
  - On NONE with hit = 1 and idx < len−1: idx++ → WAIT_PRESS.
  - On NONE with hit = 1 and idx == len−1: done pulse, idx ← 0. If mode[1] = 1 → WAIT_PRESS and mistakes are kept; otherwise → IDLE.
- **Led:** registered decode note_to_led(song[idx]) while busy; 0 in IDLE.
- **mode** is sampled every cycle; changing it mid-song takes effect on the next press.

## Timing
- note is sampled at edge t. State, idx, mistakes, done and error update at t+1. Led reflects the new idx at t+2 (one registered decode stage).
- done and error are exactly one cycle wide.
- A press and release in consecutive cycles is legal: with a correct note, idx advances two edges after the press.
- play_start in the same cycle as a note: play_start wins and the note is ignored for that cycle.
- A RESET_N assertion at any point forces IDLE immediately and clears the song length. Song memory contents are not cleared.
- idx never exceeds len−1. wr_ptr never exceeds MAX_LEN−1.

## Structure
- **Shared package piano_pkg:**
  - NONE and note code constants (C4, D, E, F, G, A, B, C5).
  - note_to_led function and LED pattern constants.
  - State enum.
- **Sub-module song_mem:** MAX_LEN × NOTE_W register file with one synchronous write port and one asynchronous read port addressed by idx. The tutor FSM, counters and Led register stay in song_tutor.

## Test plan
- Load E,E,F,G (ld_last on G); play_start; press/release E,E,F,G in strict mode with loop off → idx 0,1,2,3; done at the final release; back to IDLE; mistakes = 0; Led = 0.
- Strict mode, same song: at idx 2 press D and release → error pulse, mistakes = 1, idx = 0, Led shows E.
- Lenient mode: at idx 2 press D and release, then press F → mistakes = 1, idx stays at 2, then advances to 3.
- Hold E for 100 cycles while switching to F, then release at idx 0 → advances exactly once to idx 1; no error.
- Loop on, MIST_W = 2, with 5 wrong presses → mistakes saturates at 3; completion gives a done pulse with idx = 0 and state WAIT_PRESS.
- Load 70 beats with MAX_LEN = 64 and no ld_last → len = 64, and writes beyond 64 are accepted only as the start of a new song. Pulse RESET_N low mid-song → Led = 0, ld_ready = 1, and play_start is ignored.

Source files
------------

// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
// Package     : piano_pkg
// Description : Shared definitions for the piano keyboard blocks.
//               - Note codes. Code 0 (C_NONE) means that no key is pressed.
//               - LED patterns: one LED per note, all LEDs off for NONE.
//               - note_to_led() decode function.
//               - Tutor state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package piano_pkg;

  localparam int PKG_NOTE_W = 4;
  localparam int PKG_LED_W  = 8;

  localparam logic [PKG_NOTE_W-1:0] C_NONE = 4'd0;
  localparam logic [PKG_NOTE_W-1:0] C_C4   = 4'd1;
  localparam logic [PKG_NOTE_W-1:0] C_D    = 4'd2;
  localparam logic [PKG_NOTE_W-1:0] C_E    = 4'd3;
  localparam logic [PKG_NOTE_W-1:0] C_F    = 4'd4;
  localparam logic [PKG_NOTE_W-1:0] C_G    = 4'd5;
  localparam logic [PKG_NOTE_W-1:0] C_A    = 4'd6;
  localparam logic [PKG_NOTE_W-1:0] C_B    = 4'd7;
  localparam logic [PKG_NOTE_W-1:0] C_C5   = 4'd8;

  localparam logic [PKG_LED_W-1:0] C_LED_OFF = 8'b0000_0000;
  localparam logic [PKG_LED_W-1:0] C_LED_C4  = 8'b0000_0001;
  localparam logic [PKG_LED_W-1:0] C_LED_D   = 8'b0000_0010;
  localparam logic [PKG_LED_W-1:0] C_LED_E   = 8'b0000_0100;
  localparam logic [PKG_LED_W-1:0] C_LED_F   = 8'b0000_1000;
  localparam logic [PKG_LED_W-1:0] C_LED_G   = 8'b0001_0000;
  localparam logic [PKG_LED_W-1:0] C_LED_A   = 8'b0010_0000;
  localparam logic [PKG_LED_W-1:0] C_LED_B   = 8'b0100_0000;
  localparam logic [PKG_LED_W-1:0] C_LED_C5  = 8'b1000_0000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_PRESS = 2'd1,
    ST_WAIT_REL   = 2'd2
  } tutor_state_e;

  // Codes outside the eight named notes light nothing.
  function automatic logic [PKG_LED_W-1:0] note_to_led(input logic [PKG_NOTE_W-1:0] n);
    logic [PKG_LED_W-1:0] led;
    case (n)
      C_NONE:  led = C_LED_OFF;
      C_C4:    led = C_LED_C4;
      C_D:     led = C_LED_D;
      C_E:     led = C_LED_E;
      C_F:     led = C_LED_F;
      C_G:     led = C_LED_G;
      C_A:     led = C_LED_A;
      C_B:     led = C_LED_B;
      C_C5:    led = C_LED_C5;
      default: led = C_LED_OFF;
    endcase
    return led;
  endfunction

endpackage
`default_nettype wire

// File: rtl/song_tutor_if.sv
`default_nettype none
// ============================================================================
// Interface   : song_tutor_if
// Description : Song load port (valid/ready).
//               ld_valid / ld_note / ld_last : loader -> tutor
//               ld_ready                     : tutor -> loader
//               master = loader side, slave = tutor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface song_tutor_if #(
  parameter int NOTE_W = 4
);
  logic              ld_valid;
  logic [NOTE_W-1:0] ld_note;
  logic              ld_last;
  logic              ld_ready;

  modport master (output ld_valid, output ld_note, output ld_last, input  ld_ready);
  modport slave  (input  ld_valid, input  ld_note, input  ld_last, output ld_ready);
endinterface
`default_nettype wire

// File: rtl/song_mem.sv
`default_nettype none
// ============================================================================
// Module      : song_mem
// Description : MAX_LEN x NOTE_W register file.
//               One synchronous write port (clk, we, waddr, wdata).
//               One asynchronous read port (raddr -> rdata).
//               The contents are never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module song_mem #(
  parameter int NOTE_W  = 4,
  parameter int MAX_LEN = 64,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [IDX_W-1:0]  waddr,
  input  wire logic [NOTE_W-1:0] wdata,
  input  wire logic [IDX_W-1:0]  raddr,
  output      logic [NOTE_W-1:0] rdata
);

  logic [NOTE_W-1:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/song_tutor.sv
`default_nettype none
// ============================================================================
// Module      : song_tutor
// Description : Play-along trainer. A song is loaded through the ld port while
//               the tutor is idle. During play, Led shows the next expected note.
//               The position advances on a correct press followed by a release.
//               Ports:
//                 CLK, RESET_N        clock, asynchronous active-low reset
//                 ld (slave)          song load port, ready only in IDLE
//                 note                decoded key, 0 = no key
//                 play_start, mode    start/restart; mode[0] lenient,
//                                     mode[1] loop on completion
//                 Led, idx, mistakes  expected-note LEDs, position,
//                                     saturating mistake count
//                 busy, done, error   playing flag, completion pulse,
//                                     wrong-press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module song_tutor
  import piano_pkg::*;
#(
  parameter int NOTE_W  = 4,
  parameter int MAX_LEN = 64,
  parameter int LED_W   = 8,
  parameter int MIST_W  = 8,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  wire logic              CLK,
  input  wire logic              RESET_N,
  song_tutor_if.slave            ld,
  input  wire logic [NOTE_W-1:0] note,
  input  wire logic              play_start,
  input  wire logic [1:0]        mode,
  output      logic [LED_W-1:0]  Led,
  output      logic [IDX_W-1:0]  idx,
  output      logic [MIST_W-1:0] mistakes,
  output      logic              busy,
  output      logic              done,
  output      logic              error
);

  tutor_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  last_q, last_d;        // song length minus one
  logic              len_valid_q, len_valid_d;
  logic [MIST_W-1:0] mist_q, mist_d;
  logic              hit_q, hit_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [NOTE_W-1:0] exp_note;
  logic              load_fire;

  assign ld.ld_ready = (state_q == ST_IDLE);
  assign load_fire   = ld.ld_valid && ld.ld_ready;

  song_mem #(
    .NOTE_W  (NOTE_W),
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_song_mem (
    .clk   (CLK),
    .we    (load_fire),
    .waddr (wr_ptr_q),
    .wdata (ld.ld_note),
    .raddr (idx_q),
    .rdata (exp_note)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    last_d      = last_q;
    len_valid_d = len_valid_q;
    mist_d      = mist_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    led_d       = (state_q != ST_IDLE) ? LED_W'(note_to_led(PKG_NOTE_W'(exp_note))) : '0;

    // Song load. The first beat after a complete song starts a new one.
    // A final beat can re-validate in the same cycle (one-note song).
    if (load_fire) begin
      if (wr_ptr_q == '0 && len_valid_q) begin
        len_valid_d = 1'b0;
      end
      if (ld.ld_last || wr_ptr_q == IDX_W'(MAX_LEN - 1)) begin
        last_d      = wr_ptr_q;
        len_valid_d = 1'b1;
        wr_ptr_d    = '0;
      end else begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
      end
    end

    // An accepted start overrides whatever note is present in that cycle.
    if (play_start && len_valid_q) begin
      state_d = ST_WAIT_PRESS;
      idx_d   = '0;
      mist_d  = '0;
      hit_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_PRESS: begin
          if (note != '0) begin
            state_d = ST_WAIT_REL;
            // A stored NONE can never match, because note is non-zero here.
            if (note == exp_note) begin
              hit_d = 1'b1;
            end else begin
              hit_d = 1'b0;
              err_d = 1'b1;
              if (mist_q != '1) begin
                mist_d = mist_q + 1'b1;
              end
              if (!mode[0]) begin
                idx_d = '0;
              end
            end
          end
        end
        ST_WAIT_REL: begin
          // A change of the held key is ignored; only the release counts.
          if (note == '0) begin
            state_d = ST_WAIT_PRESS;
            if (hit_q) begin
              if (idx_q == last_q) begin
                done_d = 1'b1;
                idx_d  = '0;
                if (!mode[1]) begin
                  state_d = ST_IDLE;
                end
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      last_q      <= '0;
      len_valid_q <= 1'b0;
      mist_q      <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      last_q      <= last_d;
      len_valid_q <= len_valid_d;
      mist_q      <= mist_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      err_q       <= err_d;
      led_q       <= led_d;
    end
  end

  assign Led      = led_q;
  assign idx      = idx_q;
  assign mistakes = mist_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign error    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_song_tutor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_song_tutor
// Description : Self-checking bench for song_tutor. Two instances receive the
//               same stimulus: instance A uses MIST_W = 8 and instance B uses
//               MIST_W = 2. A behavioural model predicts all outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_tutor;

  localparam int NOTE_W  = 4;
  localparam int MAX_LEN = 64;
  localparam int LED_W   = 8;
  localparam int IDX_W   = 6;

  logic              CLK     = 1'b0;
  logic              RESET_N = 1'b1;
  logic [NOTE_W-1:0] note       = '0;
  logic              play_start = 1'b0;
  logic [1:0]        mode       = 2'b00;

  logic [LED_W-1:0]  led_a, led_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [7:0]        mist_a;
  logic [1:0]        mist_b;
  logic              busy_a, busy_b, done_a, done_b, err_a, err_b;

  song_tutor_if #(.NOTE_W(NOTE_W)) ifa ();
  song_tutor_if #(.NOTE_W(NOTE_W)) ifb ();

  always #5 CLK = ~CLK;

  song_tutor #(.NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .LED_W(LED_W), .MIST_W(8)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .ld(ifa.slave), .note(note), .play_start(play_start),
    .mode(mode), .Led(led_a), .idx(idx_a), .mistakes(mist_a), .busy(busy_a),
    .done(done_a), .error(err_a));

  song_tutor #(.NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .LED_W(LED_W), .MIST_W(2)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .ld(ifb.slave), .note(note), .play_start(play_start),
    .mode(mode), .Led(led_b), .idx(idx_b), .mistakes(mist_b), .busy(busy_b),
    .done(done_b), .error(err_b));

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_song [MAX_LEN];
  int  m_wr = 0, m_last = 0, m_pos = 0, m_miss = 0;
  bit  m_have = 0, m_busy = 0, m_down = 0, m_hit = 0;
  bit  e_done = 0, e_err = 0;
  int  e_led = 0;
  logic [1:0] cur_mode = 2'b00;

  function automatic int led_of(input int n);
    return (n >= 1 && n <= 8) ? (1 << (n - 1)) : 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input int n, input bit ps, input logic [1:0] md,
                            input bit lv, input int ln, input bit ll);
    bit start_ok;
    start_ok = ps && m_have;
    e_led    = m_busy ? led_of(m_song[m_pos]) : 0;
    e_done   = 0;
    e_err    = 0;
    if (!m_busy && lv) begin
      if (m_wr == 0 && m_have) m_have = 0;
      m_song[m_wr] = ln;
      if (ll || m_wr == MAX_LEN - 1) begin
        m_last = m_wr; m_have = 1; m_wr = 0;
      end else begin
        m_wr++;
      end
    end
    if (start_ok) begin
      m_busy = 1; m_down = 0; m_hit = 0; m_pos = 0; m_miss = 0;
    end else if (m_busy && !m_down) begin
      if (n != 0) begin
        m_down = 1;
        m_hit  = (n == m_song[m_pos]);
        if (!m_hit) begin
          e_err = 1;
          m_miss++;
          if (!md[0]) m_pos = 0;
        end
      end
    end else if (m_busy && m_down && n == 0) begin
      m_down = 0;
      if (m_hit) begin
        if (m_pos == m_last) begin
          e_done = 1; m_pos = 0; m_busy = md[1];
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("led_a",   led_a,  e_led);
    check_val("idx_a",   idx_a,  m_pos);
    check_val("mist_a",  mist_a, sat(m_miss, 255));
    check_val("busy_a",  busy_a, m_busy);
    check_val("done_a",  done_a, e_done);
    check_val("error_a", err_a,  e_err);
    check_val("ready_a", ifa.ld_ready, !m_busy);
    check_val("led_b",   led_b,  e_led);
    check_val("idx_b",   idx_b,  m_pos);
    check_val("mist_b",  mist_b, sat(m_miss, 3));
    check_val("busy_b",  busy_b, m_busy);
    check_val("done_b",  done_b, e_done);
    check_val("error_b", err_b,  e_err);
    check_val("ready_b", ifb.ld_ready, !m_busy);
  endtask

  // One clock: drive at the falling edge, check 1 ns after the rising edge.
  task automatic cycle(input int n, input bit ps, input bit lv, input int ln, input bit ll);
    note = NOTE_W'(n); play_start = ps; mode = cur_mode;
    ifa.ld_valid = lv; ifa.ld_note = NOTE_W'(ln); ifa.ld_last = ll;
    ifb.ld_valid = lv; ifb.ld_note = NOTE_W'(ln); ifb.ld_last = ll;
    model_step(n, ps, cur_mode, lv, ln, ll);
    @(posedge CLK);
    #1;
    compare_all();
    @(negedge CLK);
  endtask

  task automatic tick(input int n);
    cycle(n, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic start();
    cycle(0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic press(input int n);
    tick(n);
    tick(0);
  endtask

  task automatic do_reset();
    note = '0; play_start = 1'b0;
    ifa.ld_valid = 1'b0; ifb.ld_valid = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    m_wr = 0; m_last = 0; m_pos = 0; m_miss = 0;
    m_have = 0; m_busy = 0; m_down = 0; m_hit = 0;
    e_done = 0; e_err = 0; e_led = 0;
    compare_all();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic load_eefg();
    cycle(0, 1'b0, 1'b1, 3, 1'b0);
    cycle(0, 1'b0, 1'b1, 3, 1'b0);
    cycle(0, 1'b0, 1'b1, 4, 1'b0);
    cycle(0, 1'b0, 1'b1, 5, 1'b1);
  endtask

  initial begin
    ifa.ld_valid = 1'b0; ifa.ld_note = '0; ifa.ld_last = 1'b0;
    ifb.ld_valid = 1'b0; ifb.ld_note = '0; ifb.ld_last = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) m_song[i] = 0;
    #1 RESET_N = 1'b0;
    #1 compare_all();
    @(negedge CLK);
    RESET_N = 1'b1;
    tick(0);

    // Basic strict play-through, loop off.
    cur_mode = 2'b00;
    load_eefg();
    start();
    press(3); press(3); press(4);
    tick(5);
    tick(0);
    check_val("t1_done", done_a, 1);
    check_val("t1_idx", idx_a, 0);
    check_val("t1_busy", busy_a, 0);
    tick(0);
    check_val("t1_led_off", led_a, 0);
    check_val("t1_mist", mist_a, 0);

    // Strict: wrong note at idx 2 rewinds to the start.
    start();
    press(3); press(3);
    tick(2);
    check_val("t2_err", err_a, 1);
    tick(0);
    check_val("t2_idx", idx_a, 0);
    check_val("t2_mist", mist_a, 1);
    tick(0);
    check_val("t2_led_e", led_a, 8'h04);

    // Lenient: wrong note keeps the position.
    cur_mode = 2'b01;
    start();
    press(3); press(3); press(2);
    check_val("t3_idx_hold", idx_a, 2);
    check_val("t3_mist", mist_a, 1);
    press(4);
    check_val("t3_idx_adv", idx_a, 3);

    // A held key that changes value advances exactly once.
    cur_mode = 2'b00;
    start();
    repeat (50) tick(3);
    repeat (50) tick(4);
    tick(0);
    check_val("t4_idx", idx_a, 1);
    check_val("t4_mist", mist_a, 0);

    // Loop mode with saturation on the narrow counter.
    cur_mode = 2'b10;
    start();
    repeat (5) press(2);
    check_val("t5_mist_b_sat", mist_b, 3);
    check_val("t5_mist_a", mist_a, 5);
    press(3); press(3); press(4);
    tick(5); tick(0);
    check_val("t5_done", done_a, 1);
    check_val("t5_idx", idx_a, 0);
    check_val("t5_busy_loop", busy_a, 1);

    // Full-depth load with no ld_last, then overflow beats.
    do_reset();
    cur_mode = 2'b00;
    for (int i = 0; i < MAX_LEN; i++) cycle(0, 1'b0, 1'b1, $urandom_range(1, 8), 1'b0);
    start();
    for (int i = 0; i < MAX_LEN; i++) press(m_song[m_pos]);
    check_val("t6_done64", done_a, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1'b0, 1'b1, $urandom_range(1, 8), 1'b0);
    start();
    check_val("t6_start_ignored", busy_a, 0);

    // Reset in the middle of a song.
    load_eefg();
    start();
    press(3); tick(3);
    do_reset();
    check_val("t7_led_rst", led_a, 0);
    check_val("t7_ready_rst", ifa.ld_ready, 1);
    start();
    check_val("t7_start_ignored", busy_a, 0);

    // Randomised songs and players.
    for (int it = 0; it < 40; it++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        int nn;
        nn = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9) : $urandom_range(1, 8);
        cycle(0, 1'b0, 1'b1, nn, i == len - 1);
      end
      cur_mode = 2'($urandom_range(0, 3));
      start();
      for (int p = 0; p < 4 * len + 6 && m_busy; p++) begin
        int tgt, hold;
        if ($urandom_range(0, 7) == 0) cur_mode = 2'($urandom_range(0, 3));
        tgt = ($urandom_range(0, 3) != 0) ? m_song[m_pos] : $urandom_range(1, 9);
        if (tgt == 0) tgt = $urandom_range(1, 9);
        if ($urandom_range(0, 30) == 0) begin
          cycle(tgt, 1'b1, 1'b0, 0, 1'b0);
        end else begin
          cycle(tgt, 1'b0, $urandom_range(0, 1), $urandom_range(0, 15), 1'b0);
        end
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) tick($urandom_range(1, 15));
        if (m_busy) cycle(0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 15), 1'b0);
        else tick(0);
        if ($urandom_range(0, 1) == 0) tick(0);
      end
      if (m_busy) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
